// File: rtl/axi_bridge_pkg.sv
// Shared encodings, FSM states and the latched command record for the AXI memory bridge.
package axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_AR,
        RD_R
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_AW,
        WR_W,
        WR_B
    } wr_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
    } axi_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among eligible requesters, search starting at ptr; one-hot grant plus index.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any_gnt
);

    always_comb begin
        int idx;
        logic [PTR_W-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = PTR_W'(idx);
            if (!any_gnt && req[sel] && elig[sel]) begin
                any_gnt  = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/axi_mem_bridge.sv
// Funnels NUM_RD read clients and one write client onto a single AXI3 master port,
// one outstanding read and one outstanding write, with a same-block read-after-write stall.
module axi_mem_bridge
    import axi_bridge_pkg::*;
#(
    parameter int         NUM_RD   = 2,
    parameter int         HZ_SHIFT = 4,
    parameter logic [3:0] WR_ID    = 4'hF
) (
    input  logic                  aclk,
    input  logic                  areset,
    // read clients
    input  logic [NUM_RD-1:0]     rd_req,
    input  logic [NUM_RD*32-1:0]  rd_addr,
    input  logic [NUM_RD*4-1:0]   rd_len,
    input  logic [NUM_RD*3-1:0]   rd_size,
    output logic [NUM_RD-1:0]     rd_gnt,
    output logic [NUM_RD-1:0]     rd_valid,
    output logic [31:0]           rd_data,
    output logic                  rd_last,
    // write client
    input  logic                  wr_req,
    input  logic [31:0]           wr_addr,
    input  logic [3:0]            wr_len,
    input  logic [2:0]            wr_size,
    output logic                  wr_gnt,
    input  logic [31:0]           wr_wdata,
    input  logic [3:0]            wr_wstrb,
    input  logic                  wr_wvalid,
    output logic                  wr_wready,
    output logic                  wr_done,
    output logic                  wr_err,
    // AXI3 read address / data
    output logic [3:0]            arid,
    output logic [31:0]           araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [3:0]            rid,
    input  logic [31:0]           rdata,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    // AXI3 write address / data / response
    output logic [3:0]            awid,
    output logic [31:0]           awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [3:0]            wid,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    logic [NUM_RD-1:0][31:0] rd_addr_a;
    logic [NUM_RD-1:0][3:0]  rd_len_a;
    logic [NUM_RD-1:0][2:0]  rd_size_a;

    assign rd_addr_a = rd_addr;
    assign rd_len_a  = rd_len;
    assign rd_size_a = rd_size;

    rd_state_t          rd_state, rd_state_d;
    wr_state_t          wr_state, wr_state_d;
    axi_cmd_t           rd_cmd_q, wr_cmd_q;
    logic [PTR_W-1:0]   ptr_q, win_q, pick_idx;
    logic [NUM_RD-1:0]  elig, pick_gnt;
    logic               pick_any, pick_en, ar_hs, w_hs, wr_busy;
    logic [3:0]         beat_cnt;

    assign wr_busy = (wr_state != WR_IDLE);

    // Per-client hazard mask and rid-routed beat valid.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_client
        assign elig[gi]     = !(wr_busy && (rd_addr_a[gi][31:HZ_SHIFT] == wr_cmd_q.addr[31:HZ_SHIFT]));
        assign rd_valid[gi] = (rd_state == RD_R) && rvalid && (rid == 4'(gi));
    end

    rr_arbiter #(.N(NUM_RD), .PTR_W(PTR_W)) u_arb (
        .req     (rd_req),
        .elig    (elig),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any_gnt (pick_any)
    );

    // Arbitrate also on the final R beat so the next AR can go out the following cycle.
    assign pick_en = (rd_state == RD_IDLE) || ((rd_state == RD_R) && rvalid && rlast);
    assign ar_hs   = (rd_state == RD_AR) && arready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state <= RD_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            rd_cmd_q <= '0;
        end else begin
            rd_state <= rd_state_d;
            if (pick_en && pick_any) begin
                win_q    <= pick_idx;
                rd_cmd_q <= '{addr: rd_addr_a[pick_idx], len: rd_len_a[pick_idx], size: rd_size_a[pick_idx]};
            end
            if (ar_hs)
                ptr_q <= (win_q == PTR_W'(NUM_RD - 1)) ? '0 : win_q + PTR_W'(1);
        end
    end

    always_comb begin
        rd_state_d = rd_state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rd_last    = 1'b0;
        rd_gnt     = '0;
        case (rd_state)
            RD_IDLE: if (pick_any) rd_state_d = RD_AR;
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    rd_gnt[win_q] = 1'b1;
                    rd_state_d    = RD_R;
                end
            end
            RD_R: begin
                rready  = 1'b1;
                rd_last = rvalid && rlast;
                if (rvalid && rlast) rd_state_d = pick_any ? RD_AR : RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign arid    = 4'(win_q);
    assign araddr  = rd_cmd_q.addr;
    assign arlen   = rd_cmd_q.len;
    assign arsize  = rd_cmd_q.size;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign rd_data = rdata;

    assign w_hs = (wr_state == WR_W) && wr_wvalid && wready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state <= WR_IDLE;
            wr_cmd_q <= '0;
            beat_cnt <= '0;
        end else begin
            wr_state <= wr_state_d;
            if ((wr_state == WR_IDLE) && wr_req)
                wr_cmd_q <= '{addr: wr_addr, len: wr_len, size: wr_size};
            if (w_hs)
                beat_cnt <= wlast ? 4'd0 : beat_cnt + 4'd1;
        end
    end

    always_comb begin
        wr_state_d = wr_state;
        awvalid    = 1'b0;
        wr_gnt     = 1'b0;
        wvalid     = 1'b0;
        wr_wready  = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        wr_done    = 1'b0;
        wr_err     = 1'b0;
        case (wr_state)
            WR_IDLE: if (wr_req) wr_state_d = WR_AW;
            WR_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    wr_gnt     = 1'b1;
                    wr_state_d = WR_W;
                end
            end
            WR_W: begin
                wvalid    = wr_wvalid;
                wr_wready = wready;
                wlast     = (beat_cnt == wr_cmd_q.len);
                if (w_hs && wlast) wr_state_d = WR_B;
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    wr_done    = 1'b1;
                    wr_err     = (bresp != RESP_OKAY);
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    assign awid    = WR_ID;
    assign awaddr  = wr_cmd_q.addr;
    assign awlen   = wr_cmd_q.len;
    assign awsize  = wr_cmd_q.size;
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign wid     = WR_ID;
    assign wdata   = wr_wdata;
    assign wstrb   = wr_wstrb;

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed bench for axi_mem_bridge: reset, single read, round robin, write bursts, hazard, mid-burst reset.
module tb_axi_mem_bridge;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [1:0]  rd_req = '0;
    logic [63:0] rd_addr = '0;
    logic [7:0]  rd_len = '0;
    logic [5:0]  rd_size = '0;
    logic [1:0]  rd_gnt, rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        wr_req = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [3:0]  wr_len = '0;
    logic [2:0]  wr_size = '0;
    logic        wr_gnt;
    logic [31:0] wr_wdata = '0;
    logic [3:0]  wr_wstrb = '0;
    logic        wr_wvalid = 1'b0;
    logic        wr_wready, wr_done, wr_err;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic        rlast = 1'b0, rvalid = 1'b0;
    logic        rready;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast, wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axi_mem_bridge #(.NUM_RD(2), .HZ_SHIFT(4), .WR_ID(4'hF)) dut (
        .aclk(aclk), .areset(areset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_size(rd_size),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_size(wr_size), .wr_gnt(wr_gnt),
        .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb), .wr_wvalid(wr_wvalid), .wr_wready(wr_wready),
        .wr_done(wr_done), .wr_err(wr_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic pulse_reset();
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        rvalid = 1'b1; rid = 4'd0; wr_wvalid = 1'b1; wready = 1'b1; bvalid = 1'b1;
        @(negedge aclk); #1;
        checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++; $display("FAIL reset_valids got=%b exp=00000", {arvalid, awvalid, wvalid, rready, bready}); end
        checks++; if (rd_gnt !== 2'b00 || rd_valid !== 2'b00) begin errors++; $display("FAIL reset_rd got gnt=%b valid=%b exp 00/00", rd_gnt, rd_valid); end
        checks++; if ({wr_gnt, wr_wready, wr_done} !== 3'b0) begin errors++; $display("FAIL reset_wr got=%b exp=000", {wr_gnt, wr_wready, wr_done}); end
        checks++; if (arburst !== 2'b01 || awburst !== 2'b01 || {arlock, arcache, arprot} !== 9'd0) begin errors++; $display("FAIL reset_consts got arburst=%b awburst=%b", arburst, awburst); end
        @(negedge aclk);
        areset = 1'b0; rvalid = 1'b0; wr_wvalid = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge aclk);
        rd_req = 2'b01; rd_addr[31:0] = 32'h1FC0_0000; rd_len[3:0] = 4'd3; rd_size[2:0] = 3'd2;
        @(negedge aclk);
        arready = 1'b1; #1;
        checks++; if (arvalid !== 1'b1 || arid !== 4'd0) begin errors++; $display("FAIL sr_ar got arvalid=%b arid=%0d exp 1/0", arvalid, arid); end
        checks++; if (araddr !== 32'h1FC0_0000 || arlen !== 4'd3 || arsize !== 3'd2) begin errors++; $display("FAIL sr_addr got %h len=%0d size=%0d", araddr, arlen, arsize); end
        checks++; if (rd_gnt !== 2'b01) begin errors++; $display("FAIL sr_gnt got=%b exp=01", rd_gnt); end
        @(negedge aclk);
        arready = 1'b0; rd_req = 2'b00;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge aclk);
            rvalid = 1'b1; rid = 4'd0; rdata = 32'hA000_0000 + 32'(b); rlast = (b == 3); #1;
            checks++; if (rd_valid !== 2'b01 || rready !== 1'b1) begin errors++; $display("FAIL sr_beat%0d got valid=%b rready=%b", b, rd_valid, rready); end
            checks++; if (rd_data !== 32'hA000_0000 + 32'(b) || rd_last !== (b == 3)) begin errors++; $display("FAIL sr_data%0d got %h last=%b", b, rd_data, rd_last); end
        end
        @(negedge aclk);
        rvalid = 1'b0; rlast = 1'b0; #1;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL sr_idle got arvalid=%b rready=%b exp 0/0", arvalid, rready); end
    endtask

    task automatic test_round_robin();
        logic [3:0] last_id;
        int ng;
        last_id = 4'd0; ng = 0;
        pulse_reset();
        rd_req = 2'b11;
        rd_addr = {32'h0000_2000, 32'h0000_1000}; rd_len = 8'h00; rd_size = 6'o22;
        arready = 1'b1; rvalid = 1'b1; rlast = 1'b1;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            @(negedge aclk);
            rid = last_id; rdata = 32'(c); #1;
            if (rready) begin
                checks++; if (rd_valid !== (2'b01 << last_id)) begin errors++; $display("FAIL rr_route got=%b id=%0d", rd_valid, last_id); end
            end
            if (rd_gnt != 2'b00) begin
                checks++; if (rd_gnt !== (2'b01 << (ng % 2)) || arid !== 4'(ng % 2)) begin errors++; $display("FAIL rr_gnt%0d got gnt=%b arid=%0d exp client %0d", ng, rd_gnt, arid, ng % 2); end
                checks++; if (araddr !== ((ng % 2) ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL rr_addr%0d got %h", ng, araddr); end
                last_id = arid;
                ng++;
            end
        end
        checks++; if (ng != 4) begin errors++; $display("FAIL rr_timeout got %0d grants exp 4", ng); end
        rd_req = 2'b00;
        @(negedge aclk); rid = last_id;
        @(negedge aclk);
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_write_burst();
        @(negedge aclk);
        wr_req = 1'b1; wr_addr = 32'h0000_0100; wr_len = 4'd1; wr_size = 3'd2;
        wr_wvalid = 1'b1; wr_wdata = 32'hCAFE_0001; wr_wstrb = 4'hF;
        @(negedge aclk); #1;
        checks++; if (awvalid !== 1'b1 || awaddr !== 32'h100 || awlen !== 4'd1 || awid !== 4'hF) begin errors++; $display("FAIL wb_aw got v=%b %h len=%0d id=%h", awvalid, awaddr, awlen, awid); end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL wb_w_before_aw got wvalid=%b exp 0", wvalid); end
        awready = 1'b1; #1;
        checks++; if (wr_gnt !== 1'b1) begin errors++; $display("FAIL wb_gnt got=%b exp=1", wr_gnt); end
        @(negedge aclk);
        awready = 1'b0; wr_req = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (s > 0) @(negedge aclk);
            #1;
            checks++; if (wvalid !== 1'b1 || wr_wready !== 1'b0 || wlast !== 1'b0) begin errors++; $display("FAIL wb_stall%0d got v=%b rdy=%b last=%b", s, wvalid, wr_wready, wlast); end
        end
        @(negedge aclk);
        wready = 1'b1; #1;
        checks++; if (wr_wready !== 1'b1 || wlast !== 1'b0 || wdata !== 32'hCAFE_0001 || wstrb !== 4'hF || wid !== 4'hF) begin errors++; $display("FAIL wb_beat1 got rdy=%b last=%b %h", wr_wready, wlast, wdata); end
        @(negedge aclk);
        wr_wdata = 32'hCAFE_0002; #1;
        checks++; if (wlast !== 1'b1 || wr_wready !== 1'b1 || wdata !== 32'hCAFE_0002) begin errors++; $display("FAIL wb_beat2 got last=%b rdy=%b %h", wlast, wr_wready, wdata); end
        @(negedge aclk); #1;
        checks++; if (wvalid !== 1'b0 || wr_wready !== 1'b0 || bready !== 1'b1 || wr_done !== 1'b0) begin errors++; $display("FAIL wb_extra got v=%b rdy=%b bready=%b done=%b", wvalid, wr_wready, bready, wr_done); end
        @(negedge aclk);
        bvalid = 1'b1; bresp = 2'b00; #1;
        checks++; if (wr_done !== 1'b1 || wr_err !== 1'b0) begin errors++; $display("FAIL wb_done got done=%b err=%b exp 1/0", wr_done, wr_err); end
        @(negedge aclk);
        bvalid = 1'b0; wr_wvalid = 1'b0; #1;
        checks++; if (bready !== 1'b0 || awvalid !== 1'b0) begin errors++; $display("FAIL wb_idle got bready=%b awvalid=%b", bready, awvalid); end
        // single-beat write answered with SLVERR
        wr_req = 1'b1; wr_addr = 32'h0000_0140; wr_len = 4'd0; awready = 1'b1; wr_wvalid = 1'b1; wready = 1'b1;
        @(negedge aclk); #1;
        checks++; if (wr_gnt !== 1'b1) begin errors++; $display("FAIL we_gnt got=%b exp=1", wr_gnt); end
        @(negedge aclk);
        wr_req = 1'b0; awready = 1'b0; #1;
        checks++; if (wlast !== 1'b1 || wr_wready !== 1'b1) begin errors++; $display("FAIL we_len0 got last=%b rdy=%b", wlast, wr_wready); end
        @(negedge aclk);
        wr_wvalid = 1'b0; bvalid = 1'b1; bresp = 2'b10; #1;
        checks++; if (wr_done !== 1'b1 || wr_err !== 1'b1) begin errors++; $display("FAIL we_err got done=%b err=%b exp 1/1", wr_done, wr_err); end
        @(negedge aclk);
        bvalid = 1'b0; bresp = 2'b00; wready = 1'b0;
    endtask

    task automatic test_hazard();
        int seen;
        seen = -1;
        pulse_reset();
        wr_req = 1'b1; wr_addr = 32'h0000_0104; wr_len = 4'd0; awready = 1'b1; wr_wvalid = 1'b1; wready = 1'b1;
        @(negedge aclk);
        wr_req = 1'b0;
        rd_req = 2'b10; rd_addr[63:32] = 32'h0000_010C; rd_len[7:4] = 4'd0; #1;
        checks++; if (wr_gnt !== 1'b1) begin errors++; $display("FAIL hz_wgnt got=%b exp=1", wr_gnt); end
        @(negedge aclk);
        awready = 1'b0;
        @(negedge aclk);
        wr_wvalid = 1'b0; wready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk); #1;
            checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL hz_block%0d got arvalid=%b exp 0", c, arvalid); end
        end
        rd_req = 2'b11; rd_addr[31:0] = 32'h0000_0200; rd_len[3:0] = 4'd0; arready = 1'b1;
        @(negedge aclk); #1;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h200 || arid !== 4'd0 || rd_gnt !== 2'b01) begin errors++; $display("FAIL hz_other got v=%b %h id=%0d gnt=%b", arvalid, araddr, arid, rd_gnt); end
        rd_req = 2'b10;
        @(negedge aclk);
        rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; #1;
        checks++; if (rd_valid !== 2'b01 || rd_last !== 1'b1) begin errors++; $display("FAIL hz_other_beat got valid=%b last=%b", rd_valid, rd_last); end
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            rvalid = 1'b0; rlast = 1'b0; #1;
            checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL hz_still%0d got arvalid=%b exp 0", c, arvalid); end
        end
        @(negedge aclk);
        bvalid = 1'b1; #1;
        checks++; if (wr_done !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL hz_done got done=%b arvalid=%b exp 1/0", wr_done, arvalid); end
        for (int c = 1; c <= 6 && seen < 0; c++) begin
            @(negedge aclk);
            bvalid = 1'b0; #1;
            if (arvalid) seen = c;
        end
        checks++; if (seen < 1 || araddr !== 32'h10C || arid !== 4'd1 || rd_gnt !== 2'b10) begin errors++; $display("FAIL hz_release got seen=%0d %h id=%0d gnt=%b", seen, araddr, arid, rd_gnt); end
        rd_req = 2'b00;
        @(negedge aclk);
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; #1;
        checks++; if (rd_valid !== 2'b10) begin errors++; $display("FAIL hz_release_beat got=%b exp=10", rd_valid); end
        @(negedge aclk);
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        @(negedge aclk);
        rd_req = 2'b01; rd_addr = {32'h0000_0400, 32'h0000_0300}; rd_len = 8'h03; arready = 1'b1;
        @(negedge aclk); #1;
        checks++; if (rd_gnt !== 2'b01) begin errors++; $display("FAIL mr_gnt got=%b exp=01", rd_gnt); end
        rd_req = 2'b00;
        @(negedge aclk);
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (b > 0) @(negedge aclk);
            rvalid = 1'b1; rid = 4'd0; rlast = 1'b0; #1;
            checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL mr_beat%0d got=%b exp=01", b, rd_valid); end
        end
        @(negedge aclk);
        areset = 1'b1; #1;
        checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0 || rd_valid !== 2'b00) begin errors++; $display("FAIL mr_abort got=%b valid=%b", {arvalid, rready, awvalid, wvalid, bready}, rd_valid); end
        @(negedge aclk);
        areset = 1'b0; rvalid = 1'b0; rd_req = 2'b11;
        @(negedge aclk); #1;
        checks++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h300) begin errors++; $display("FAIL mr_ptr got v=%b id=%0d %h exp client 0", arvalid, arid, araddr); end
        arready = 1'b1; rd_req = 2'b00;
        @(negedge aclk);
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rd_len = 8'h00;
        @(negedge aclk);
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_burst();
        test_hazard();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_mem_bridge.md
Name: axi_mem_bridge

Overview:
- Parametrised successor to the CPU top-level AXI glue.
- Arbitrates NUM_RD independent read clients (I-cache, D-cache, uncached) and one write client onto a single AXI3 master port.
- Supports INCR bursts and a read-after-write hazard stall.
- Sits between the mips core's cache/uncached request ports and the external AXI interconnect.

Parameters:
- NUM_RD, 2, number of read clients; client i drives arid = i (NUM_RD <= 15).
- HZ_SHIFT, 4, address bits dropped for the read-after-write hazard compare (16-byte block).
- WR_ID, 4'hF, fixed AWID/WID value.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- rd_req  in  NUM_RD  per-client read request; held until rd_gnt.
- rd_addr  in  NUM_RD*32  per-client byte address, client i at [32i+31:32i].
- rd_len  in  NUM_RD*4  per-client burst length minus 1.
- rd_size  in  NUM_RD*3  per-client AXI size code.
- rd_gnt  out  NUM_RD  one-cycle pulse; request accepted (AR handshake done).
- rd_valid  out  NUM_RD  beat valid for the owning client.
- rd_data  out  32  beat data, shared by all clients.
- rd_last  out  1  final beat.
- wr_req, wr_addr[32], wr_len[4], wr_size[3]  in  write request, held until wr_gnt.
- wr_gnt  out  1  pulse on AW handshake.
- wr_wdata[32], wr_wstrb[4], wr_wvalid  in  write beat stream.
- wr_wready  out  1  beat accepted.
- wr_done  out  1  pulse on B handshake; carries wr_err = (bresp != 0).
- wr_err  out  1  error flag, valid with wr_done.
- AXI3 master ports ar*/r*/aw*/w*/b*: widths as on the existing CPU top (arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3; same set for aw*; wid 4, wstrb 4).

Behaviour:
- Constants: arburst = awburst = 2'b01; lock, cache and prot = 0; wlast driven from the beat counter.
- Reset values: arvalid, awvalid, wvalid, rready, bready, rd_gnt, rd_valid, wr_gnt, wr_wready, wr_done all 0; round-robin pointer = 0; both FSMs idle. Reset mid-burst aborts silently; no resume.
- Read FSM, one outstanding read:
  - RD_IDLE -> RD_AR: when any eligible rd_req is high. Round-robin pick starts at ptr; registered winner drives araddr/arlen/arsize/arid; arvalid = 1.
  - RD_AR -> RD_R: on arvalid & arready. Pulse rd_gnt[winner]; ptr = winner+1 mod NUM_RD.
  - RD_R: rready = 1; rd_valid[rid] = rvalid with rd_data = rdata combinationally. On rvalid & rlast -> RD_IDLE.
  - Beats whose rid mismatches the winner are still routed by rid.
  - Earliest next arvalid is the cycle after rlast.
- Hazard: client i is ineligible while the write FSM is past WR_IDLE (AW issued, B not yet received) and rd_addr_i[31:HZ_SHIFT] == wr_addr_q[31:HZ_SHIFT]. An ineligible client is skipped and the pointer is not advanced for it.
- Write FSM:
  - WR_IDLE -> WR_AW: on wr_req; latch addr, len, size.
  - WR_AW -> WR_W: on awready; pulse wr_gnt.
  - WR_W: wvalid = wr_wvalid; wr_wready = wready; beat counter increments on each handshake; wlast = (cnt == len_q). Last handshake -> WR_B.
  - WR_B: bready = 1; on bvalid pulse wr_done -> WR_IDLE.
  - W data is never issued before the AW handshake.
- Simultaneous events:
  - Read and write FSMs are fully independent.
  - The hazard check uses the registered wr_addr_q, so a read and a write to the same block requested in the same cycle both proceed (the write has not issued AW).
  - len = 0 gives a single beat with wlast/rd_last on the first beat.
- Beat counter is 4 bits with no wrap past len_q; an extra beat (wr_wvalid after wlast) is not accepted while in WR_B.

Decomposition:
- Package axi_bridge_pkg: AXI burst/resp encodings, read FSM state enum, write FSM state enum.
- One sub-module: rr_arbiter (NUM_RD requests + eligibility mask + ptr -> one-hot grant). Everything else lives in axi_mem_bridge.

Test Plan:
- Single read: client 0, addr 0x1FC0_0000, len 3; slave returns 4 beats -> arid 0, arlen 3, rd_valid[0] x4, rd_last on beat 4.
- Round robin: clients 0 and 1 request continuously -> grants alternate 0,1,0,1; arid matches each grant.
- Write burst: addr 0x0000_0100, len 1, strb 4'hF; wready stalls 2 cycles -> wlast on beat 2 only, wr_done after bvalid, wr_err 0. bresp = 2'b10 -> wr_err 1.
- Hazard: write to 0x0000_0104 awaiting B; client 1 reads 0x0000_010C -> no arvalid until the cycle after wr_done. A read of 0x0000_0200 proceeds concurrently.
- Reset mid-read after beat 2 of 4 -> next cycle all valids and readies are 0, FSMs idle, ptr 0.
